// File: rtl/serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_tx
// Description : Parallel-to-serial word transmitter for the 1101 sequence
//               detector. A word offered on in_valid/data_in is accepted in
//               IDLE and then driven MSB-first on serial_out, one bit per
//               clk_2 cycle. A programmable idle gap follows every frame.
//
//               Optional feature macro: SERIAL_PARITY_EN
//                 defined   -> an even-parity bit (^word) follows the data
//                              bits, so the frame is NBITS+1 bits long
//                 undefined -> the frame is exactly NBITS bits
//
// Ports       : clk_2        clock, all state changes on the rising edge
//               reset        synchronous, active-high
//               in_valid     word on data_in is offered
//               data_in      word to transmit (NBITS)
//               in_ready     transmitter accepts a word this cycle
//               serial_out   serial bit stream (IDLE_LEVEL when no bit)
//               serial_valid serial_out carries a frame bit
//               bit_cnt      index of the data bit on serial_out
//               busy         frame or gap in progress
//               done         one-cycle pulse after the last frame bit
//
// Revision    : 1.0  initial release
// ============================================================================
module serial_word_tx #(
    parameter int   NBITS      = 8,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                     clk_2,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [NBITS-1:0]         data_in,
    output logic                     in_ready,
    output logic                     serial_out,
    output logic                     serial_valid,
    output logic [$clog2(NBITS)-1:0] bit_cnt,
    output logic                     busy,
    output logic                     done
);

    localparam int CW = $clog2(NBITS);
    // Gap counter only has to hold GAP_CYCLES-1; keep at least one bit.
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CW-1:0] c_CNT_TOP  = CW'(NBITS - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
    localparam logic [GW-1:0] c_GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_GAP    = 2'd2
`ifdef SERIAL_PARITY_EN
        ,
        S_PARITY = 2'd3
`endif
    } state_t;

    state_t           r_state;
    logic [NBITS-1:0] r_word;
    logic [GW-1:0]    r_gap_cnt;
    logic             r_in_ready;
    logic             r_serial_out;
    logic             r_serial_valid;
    logic [CW-1:0]    r_bit_cnt;
    logic             r_busy;
    logic             r_done;
    logic             w_frame_end;

    // The edge that closes the frame: after the last data bit, or after the
    // parity bit when parity is built in.
`ifdef SERIAL_PARITY_EN
    assign w_frame_end = (r_state == S_PARITY);
`else
    assign w_frame_end = (r_state == S_SHIFT) && (r_bit_cnt == '0);
`endif

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_word         <= '0;
            r_gap_cnt      <= '0;
            r_in_ready     <= 1'b1;
            r_serial_out   <= IDLE_LEVEL;
            r_serial_valid <= 1'b0;
            r_bit_cnt      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_frame_end) begin
                r_done         <= 1'b1;
                r_serial_valid <= 1'b0;
                r_serial_out   <= IDLE_LEVEL;
                r_bit_cnt      <= '0;
                if (GAP_CYCLES > 0) begin
                    // The done cycle is the first gap cycle.
                    r_state   <= S_GAP;
                    r_gap_cnt <= c_GAP_LAST;
                end else begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (in_valid) begin
                            r_word         <= data_in;
                            r_serial_out   <= data_in[NBITS-1];
                            r_bit_cnt      <= c_CNT_TOP;
                            r_serial_valid <= 1'b1;
                            r_busy         <= 1'b1;
                            r_in_ready     <= 1'b0;
                            r_state        <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        // bit_cnt==0 here only with parity enabled: the
                        // parity bit replaces the data stream for a cycle.
                        if (r_bit_cnt == '0) begin
`ifdef SERIAL_PARITY_EN
                            r_serial_out <= ^r_word;
                            r_state      <= S_PARITY;
`endif
                        end else begin
                            r_bit_cnt    <= r_bit_cnt - c_CNT_ONE;
                            r_serial_out <= r_word[r_bit_cnt - c_CNT_ONE];
                        end
                    end
                    S_GAP: begin
                        if (r_gap_cnt == '0) begin
                            r_state    <= S_IDLE;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - GW'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign serial_out   = r_serial_out;
    assign serial_valid = r_serial_valid;
    assign bit_cnt      = r_bit_cnt;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_tx
// Description : Self-checking bench for serial_word_tx. Two instances share
//               the stimulus: one with a 2-cycle gap, one with no gap.
//               A frame-level reference model predicts every output cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_word_tx;

    localparam int NB = 8;
    localparam int CW = 3;
`ifdef SERIAL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F = NB + PAR;

    logic clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    logic          reset    = 1'b1;
    logic          in_valid = 1'b0;
    logic [NB-1:0] data_in  = '0;

    logic          a_in_ready, a_serial_out, a_serial_valid, a_busy, a_done;
    logic [CW-1:0] a_bit_cnt;
    logic          b_in_ready, b_serial_out, b_serial_valid, b_busy, b_done;
    logic [CW-1:0] b_bit_cnt;

    serial_word_tx #(.NBITS(NB), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut_g2 (
        .clk_2(clk_2), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .in_ready(a_in_ready), .serial_out(a_serial_out), .serial_valid(a_serial_valid),
        .bit_cnt(a_bit_cnt), .busy(a_busy), .done(a_done));

    serial_word_tx #(.NBITS(NB), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut_g0 (
        .clk_2(clk_2), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .in_ready(b_in_ready), .serial_out(b_serial_out), .serial_valid(b_serial_valid),
        .bit_cnt(b_bit_cnt), .busy(b_busy), .done(b_done));

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          rdy;
        logic          so;
        logic          sv;
        logic [CW-1:0] cnt;
        logic          busy;
        logic          done;
    } rec_t;

    localparam rec_t IDLE_REC = '{rdy: 1'b1, so: 1'b0, sv: 1'b0, cnt: '0, busy: 1'b0, done: 1'b0};

    function automatic logic fbit(input logic [NB-1:0] w, input int idx);
        if (idx < NB) return w[NB-1-idx];
        return ^w;
    endfunction

    // Output record for cycle i (0-based) after the accept edge of word w.
    function automatic rec_t frame_rec(input logic [NB-1:0] w, input int gap, input int i);
        rec_t r;
        r = '{rdy: 1'b0, so: 1'b0, sv: 1'b0, cnt: '0, busy: 1'b1, done: 1'b0};
        if (i < F) begin
            r.so = fbit(w, i);
            r.sv = 1'b1;
            if (i < NB) r.cnt = CW'(NB - 1 - i);
        end else if (gap == 0) begin
            r.rdy  = 1'b1;
            r.busy = 1'b0;
            r.done = 1'b1;
        end else begin
            r.done = (i == F);
        end
        return r;
    endfunction

    function automatic int flen(input int gap);
        return F + ((gap == 0) ? 1 : gap);
    endfunction

    rec_t q2[$];
    rec_t q0[$];
    rec_t m_c2, m_c0;

    always @(posedge clk_2) begin
        m_c2 = (q2.size() > 0) ? q2[0] : IDLE_REC;
        m_c0 = (q0.size() > 0) ? q0[0] : IDLE_REC;
        if (reset) begin
            q2.delete();
            q0.delete();
        end else begin
            if (q2.size() > 0) void'(q2.pop_front());
            if (q0.size() > 0) void'(q0.pop_front());
            if (in_valid && m_c2.rdy)
                for (int i = 0; i < flen(2); i++) q2.push_back(frame_rec(data_in, 2, i));
            if (in_valid && m_c0.rdy)
                for (int i = 0; i < flen(0); i++) q0.push_back(frame_rec(data_in, 0, i));
        end
    end

    rec_t e2, e0;
    always @(negedge clk_2) begin
        if (chk_en) begin
            e2 = (q2.size() > 0) ? q2[0] : IDLE_REC;
            e0 = (q0.size() > 0) ? q0[0] : IDLE_REC;
            check("model_gap2", {a_in_ready, a_serial_out, a_serial_valid, a_bit_cnt, a_busy, a_done}, e2);
            check("model_gap0", {b_in_ready, b_serial_out, b_serial_valid, b_bit_cnt, b_busy, b_done}, e0);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_ready2();
        int n = 0;
        while (!a_in_ready && n < 100) begin
            @(negedge clk_2);
            n++;
        end
        check("wait_ready", a_in_ready, 1'b1);
    endtask

    typedef struct {
        logic [NB-1:0] w;
        logic          par;
    } vec_t;
    vec_t tbl[8];

    logic [NB-1:0] exp_bits;
    logic [NB:0]   col;
    int            nval, ndone;

    initial begin
        tbl[0] = '{8'h0D, 1'b1};
        tbl[1] = '{8'h0F, 1'b0};
        tbl[2] = '{8'hA5, 1'b0};
        tbl[3] = '{8'h3C, 1'b0};
        tbl[4] = '{8'hFF, 1'b0};
        tbl[5] = '{8'h00, 1'b0};
        tbl[6] = '{8'h80, 1'b1};
        tbl[7] = '{8'h01, 1'b1};

        // Reset
        @(posedge clk_2);
        #1 chk_en = 1'b1;
        @(negedge clk_2);
        check("reset_ready", a_in_ready, 1'b1);
        check("reset_out", {a_serial_out, a_serial_valid, a_bit_cnt, a_busy, a_done}, '0);
        reset = 1'b0;
        @(negedge clk_2);

        // Basic frame with a stray offer during the frame
        wait_ready2();
        in_valid = 1'b1;
        data_in  = 8'h0D;
        exp_bits = 8'b0000_1101;
        @(posedge clk_2);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk_2);
            if (k == 1) in_valid = 1'b0;
            if (k == 3) begin
                in_valid = 1'b1;
                data_in  = 8'hFF;
            end
            if (k == 4) in_valid = 1'b0;
            if (k <= 8) begin
                check("t1_bit", a_serial_out, exp_bits[8-k]);
                check("t1_cnt", a_bit_cnt, 32'(8 - k));
                check("t1_valid", a_serial_valid, 1'b1);
            end
            if (PAR == 1 && k == 9) check("t5_parity", a_serial_out, 1'b1);
            check("t1_done", a_done, (k == 9 + PAR) ? 1'b1 : 1'b0);
            check("t1_ready", a_in_ready, (k >= 11 + PAR) ? 1'b1 : 1'b0);
        end

        // Reset in the middle of a frame
        wait_ready2();
        in_valid = 1'b1;
        data_in  = 8'h0D;
        @(posedge clk_2);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk_2);
            if (k == 1) in_valid = 1'b0;
            if (k == 4) reset = 1'b1;
            if (k == 5) begin
                check("t3_reset", {a_in_ready, a_serial_out, a_serial_valid, a_busy}, 4'b1000);
                reset = 1'b0;
            end
            if (k > 5) check("t3_no_done", a_done, 1'b0);
        end

        // Back-to-back on the no-gap instance
        in_valid = 1'b1;
        data_in  = 8'hA5;
        @(posedge clk_2);
        #1 data_in = 8'h3C;
        for (int k = 1; k <= 2 * F + 1; k++) begin
            @(negedge clk_2);
            if (k == F + 2) in_valid = 1'b0;
            if (k <= F) begin
                check("t4_valid_a", b_serial_valid, 1'b1);
                check("t4_bit_a", b_serial_out, fbit(8'hA5, k - 1));
            end else if (k == F + 1) begin
                check("t4_gapcycle", {b_serial_valid, b_done, b_in_ready}, 3'b011);
            end else begin
                check("t4_valid_b", b_serial_valid, 1'b1);
                check("t4_bit_b", b_serial_out, fbit(8'h3C, k - F - 2));
            end
        end

        // Table of words through the gap-2 instance
        for (int t = 0; t < 8; t++) begin
            wait_ready2();
            in_valid = 1'b1;
            data_in  = tbl[t].w;
            @(posedge clk_2);
            col   = '0;
            nval  = 0;
            ndone = 0;
            for (int k = 1; k <= 16; k++) begin
                @(negedge clk_2);
                if (k == 1) in_valid = 1'b0;
                if (a_serial_valid) begin
                    col = {col[NB-1:0], a_serial_out};
                    nval++;
                end
                if (a_done) ndone++;
            end
            check("tbl_nbits", nval, F);
            check("tbl_ndone", ndone, 1);
            if (PAR == 1) begin
                check("tbl_word", col[NB:1], tbl[t].w);
                check("tbl_parity", col[0], tbl[t].par);
            end else begin
                check("tbl_word", col[NB-1:0], tbl[t].w);
            end
        end

        // Random traffic, checked by the model every cycle
        for (int n = 0; n < 600; n++) begin
            @(negedge clk_2);
            reset    = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 2) == 0);
            data_in  = NB'($urandom);
        end
        @(negedge clk_2);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (20) @(negedge clk_2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
